// File: rtl/jtsdram_beep_seq.sv
// jtsdram_beep_seq: SDRAM-test beep sequencer. It visits the done banks in
// round-robin order and beeps each one's pass/fail code, timed in LHBL lines.
// Ports: clk, rst_n (sync, active low), LHBL (rising edge = line tick),
//   dwnld_busy (forces silence), done/bad [BANKS] (checker status),
//   tone_en, tone_step[4:0] (tone accumulator), cur_bank[2:0], busy.
// Option: JTSDRAM_SILENT_OK_EN beeps only banks that are done and bad.
module jtsdram_beep_seq #(
  parameter int         BANKS       = 4,
  parameter int         BEEP_LINES  = 1024,
  parameter int         GAP_LINES   = 512,
  parameter int         PAUSE_LINES = 4096,
  parameter logic [4:0] STEP_OK     = 5'd1,
  parameter logic [4:0] STEP_BAD    = 5'd3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             LHBL,
  input  logic             dwnld_busy,
  input  logic [BANKS-1:0] done,
  input  logic [BANKS-1:0] bad,
  output logic             tone_en,
  output logic [4:0]       tone_step,
  output logic [2:0]       cur_bank,
  output logic             busy
);

  localparam int BG =
    BEEP_LINES > GAP_LINES ? BEEP_LINES : GAP_LINES;
  localparam int MAXL =
    BG > PAUSE_LINES ? BG : PAUSE_LINES;
  localparam int CW = $clog2(MAXL + 1);

  localparam logic [CW-1:0] BEEP_LD  = CW'(BEEP_LINES - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_LINES - 1);
  localparam logic [CW-1:0] PAUSE_LD = CW'(PAUSE_LINES - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [2:0] {
    IDLE, SELECT, BEEP, GAP, PAUSE
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [3:0]      left, left_nxt;
  logic [2:0]      last, last_nxt;
  logic [2:0]      bank_nxt;
  logic [4:0]      step_nxt;
  logic            ten_nxt;
  logic            last_lhbl;
  logic            tick;
  logic [BANKS-1:0] cand;
  logic [7:0]      cand8, bad8;
  logic [2:0]      pick;
  logic            found;
  logic [3:0]      j;

`ifdef JTSDRAM_SILENT_OK_EN
  assign cand = done & bad;
`else
  assign cand = done;
`endif

  assign tick = LHBL & ~last_lhbl;
  assign busy = state != IDLE;

  // Round-robin search: first candidate after the last served bank
  always_comb begin
    cand8 = 8'(cand);
    bad8  = 8'(bad);
    found = 1'b0;
    pick  = '0;
    j     = '0;
    for (int i = 1; i <= BANKS; i++) begin
      j = {1'b0, last} + 4'(i);
      if (j >= 4'(BANKS))
        j = j - 4'(BANKS);
      if (!found && cand8[j[2:0]]) begin
        found = 1'b1;
        pick  = j[2:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    left_nxt  = left;
    last_nxt  = last;
    bank_nxt  = cur_bank;
    step_nxt  = tone_step;
    unique case (state)
      IDLE: begin
        if (|cand)
          state_nxt = SELECT;
      end
      SELECT: begin
        if (found) begin
          state_nxt = BEEP;
          bank_nxt  = pick;
          last_nxt  = pick;
          cnt_nxt   = BEEP_LD;
          step_nxt  = bad8[pick] ? STEP_BAD : STEP_OK;
          left_nxt  = bad8[pick] ?
                      {1'b0, pick} + 4'd1 : 4'd1;
        end else begin
          state_nxt = IDLE;
        end
      end
      BEEP: begin
        if (tick) begin
          if (cnt == '0) begin
            left_nxt = left - 4'd1;
            if (left == 4'd1) begin
              state_nxt = PAUSE;
              cnt_nxt   = PAUSE_LD;
            end else begin
              state_nxt = GAP;
              cnt_nxt   = GAP_LD;
            end
          end else begin
            cnt_nxt = cnt - ONE;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (cnt == '0) begin
            state_nxt = BEEP;
            cnt_nxt   = BEEP_LD;
          end else begin
            cnt_nxt = cnt - ONE;
          end
        end
      end
      PAUSE: begin
        if (tick) begin
          if (cnt == '0)
            state_nxt = IDLE;
          else
            cnt_nxt = cnt - ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (dwnld_busy)
      state_nxt = IDLE;
    // tone follows the state one clock later, cut at once by download
    ten_nxt = (state == BEEP) && !dwnld_busy;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      left      <= '0;
      last      <= 3'(BANKS - 1);
      cur_bank  <= '0;
      tone_step <= '0;
      tone_en   <= 1'b0;
      last_lhbl <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      left      <= left_nxt;
      last      <= last_nxt;
      cur_bank  <= bank_nxt;
      tone_step <= step_nxt;
      tone_en   <= ten_nxt;
      last_lhbl <= LHBL;
    end
  end

endmodule

// File: tb/tb_jtsdram_beep_seq.sv
// tb_jtsdram_beep_seq: directed bench for jtsdram_beep_seq.
// BANKS=4, BEEP=4, GAP=2, PAUSE=8 lines; one line tick every 16 clk.
module tb_jtsdram_beep_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       LHBL;
  logic       dwnld_busy;
  logic [3:0] done;
  logic [3:0] bad;
  logic       tone_en;
  logic [4:0] tone_step;
  logic [2:0] cur_bank;
  logic       busy;

  int n_chk = 0;
  int n_pass = 0;
  int ph = 0;
  int n;

  jtsdram_beep_seq #(
    .BANKS(4),
    .BEEP_LINES(4),
    .GAP_LINES(2),
    .PAUSE_LINES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .LHBL(LHBL),
    .dwnld_busy(dwnld_busy),
    .done(done),
    .bad(bad),
    .tone_en(tone_en),
    .tone_step(tone_step),
    .cur_bank(cur_bank),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // LHBL: 8 clk low, 8 clk high; changes just after posedge
  initial begin
    LHBL = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      ph = (ph + 1) % 16;
      LHBL = (ph >= 8);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic hi_run(output int len);
    len = 0;
    while (tone_en === 1'b1 && len < 4000) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic lo_run(output int len);
    len = 0;
    while (tone_en !== 1'b1 && len < 4000) begin
      len++;
      @(negedge clk);
    end
  endtask

  // after return, the next posedge is one clk past a tick edge
  task automatic align9();
    int k;
    k = 0;
    while (ph != 9 && k < 40) begin
      k++;
      @(negedge clk);
    end
  endtask

  task automatic beep(input string tag, input int len,
                      input int bk, input int st);
    int m;
    check({tag, "_bank"}, 32'(cur_bank), bk);
    check({tag, "_step"}, 32'(tone_step), st);
    hi_run(m);
    check({tag, "_len"}, m, len);
  endtask

  task automatic silence(input string tag, input int len);
    int m;
    lo_run(m);
    check(tag, m, len);
  endtask

  initial begin
    rst_n = 1'b0;
    dwnld_busy = 1'b0;
    done = 4'hF;
`ifdef JTSDRAM_SILENT_OK_EN
    bad = 4'b1000;
`else
    bad = 4'b0000;
`endif
    repeat (5) @(negedge clk);
    check("rst_tone_en", 32'(tone_en), 0);
    check("rst_step", 32'(tone_step), 0);
    check("rst_bank", 32'(cur_bank), 0);
    check("rst_busy", 32'(busy), 0);
    align9();
    rst_n = 1'b1;
    silence("first_lat", 3);

`ifdef JTSDRAM_SILENT_OK_EN
    beep("s3a", 62, 3, 3);
    silence("s3g1", 32);
    beep("s3b", 64, 3, 3);
    silence("s3g2", 32);
    beep("s3c", 64, 3, 3);
    silence("s3g3", 32);
    beep("s3d", 64, 3, 3);
    silence("s3p", 130);
    beep("s3again", 62, 3, 3);
    bad = 4'b0000;
    repeat (800) @(negedge clk);
    check("s_idle_busy", 32'(busy), 0);
    check("s_idle_tone", 32'(tone_en), 0);
`else
    // all banks passing: 0,1,2,3,0 single beeps
    beep("rr0", 62, 0, 1);
    silence("rr0_p", 130);
    beep("rr1", 62, 1, 1);
    silence("rr1_p", 130);
    beep("rr2", 62, 2, 1);
    silence("rr2_p", 130);
    beep("rr3", 62, 3, 1);
    silence("rr3_p", 130);
    beep("rr0b", 62, 0, 1);

    // only bank 2 done and failing: three beeps
    done = 4'b0100;
    bad = 4'b0100;
    silence("rr0b_p", 130);
    beep("b2a", 62, 2, 3);
    silence("b2g1", 32);
    beep("b2b", 64, 2, 3);
    silence("b2g2", 32);
    beep("b2c", 64, 2, 3);
    silence("b2p", 130);
    beep("b2r_a", 62, 2, 3);
    silence("b2r_g1", 32);

    // download pulse inside the second beep
    repeat (5) @(negedge clk);
    dwnld_busy = 1'b1;
    @(negedge clk);
    check("dl_tone", 32'(tone_en), 0);
    check("dl_busy", 32'(busy), 0);
    repeat (20) @(negedge clk);
    check("dl_hold_busy", 32'(busy), 0);
    align9();
    dwnld_busy = 1'b0;
    silence("dl_lat", 3);
    beep("dl_a", 62, 2, 3);
    silence("dl_g1", 32);

    // done drops mid-code: code still completes
    done = 4'b0011;
    bad = 4'b0000;
    beep("dl_b", 64, 2, 3);
    silence("dl_g2", 32);
    beep("dl_c", 64, 2, 3);
    silence("dl_p", 130);

    // bad[1] rises during bank 1's beep
    beep("t4_b0", 62, 0, 1);
    silence("t4_b0p", 130);
    check("t4_b1_bank", 32'(cur_bank), 1);
    check("t4_b1_step", 32'(tone_step), 1);
    repeat (20) @(negedge clk);
    bad = 4'b0010;
    hi_run(n);
    check("t4_b1_len", n, 42);
    check("t4_b1_hold", 32'(tone_step), 1);
    silence("t4_b1p", 130);
    beep("t4_b0b", 62, 0, 1);
    silence("t4_b0bp", 130);
    beep("t4_b1b", 62, 1, 3);

    // reset in the gap of bank 1's two-beep code
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rr_tone", 32'(tone_en), 0);
    check("rr_step", 32'(tone_step), 0);
    check("rr_bank", 32'(cur_bank), 0);
    check("rr_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    align9();
    rst_n = 1'b1;
    silence("rr_lat", 3);
    beep("rr_first", 62, 0, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
